// File: rtl/cache_req_ctrl_pkg.sv
// ============================================================================
// cache_req_ctrl_pkg : shared state encodings, timeout default, request check
// Revision: 1.0
// ============================================================================
`default_nettype none

package cache_req_ctrl_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam int TIMEOUT_DEFAULT = 64;

   // A request is legal only with exactly one strobe and a halfword-aligned address.
   function automatic logic req_legal(input logic rd_i, input logic wr_i, input logic a0_i);
      return (rd_i ^ wr_i) & ~a0_i;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dff_r.sv
// ============================================================================
// dff_r : D flop bank with synchronous active-high reset to RST_VAL
// Revision: 1.0
// ============================================================================
`default_nettype none

module dff_r #(
   parameter int                 WIDTH   = 1,
   parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   always_ff @(posedge clk) begin
      if (rst) q_o <= RST_VAL;
      else     q_o <= d_i;
   end

endmodule

`default_nettype wire

// File: rtl/sat_counter16.sv
// ============================================================================
// sat_counter16 : 16-bit up counter, sticks at 16'hFFFF, synchronous reset
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_counter16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc_i,
   output logic [15:0] cnt_o
);

   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= 16'h0000;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/cache_req_ctrl.sv
// ============================================================================
// cache_req_ctrl : holds one processor load/store toward the cache controller
// Revision: 1.0
// ============================================================================
`default_nettype none

module cache_req_ctrl
   import cache_req_ctrl_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr_in,
   input  logic [15:0] data_in,
   input  logic        rd_in,
   input  logic        wr_in,
   output logic [15:0] data_out,
   output logic        done_proc,
   output logic        stall_proc,
   output logic        err,
   output logic [15:0] addr,
   output logic [15:0] data,
   output logic        rd,
   output logic        wr,
   input  logic        done,
   input  logic        cache_hit,
   input  logic [15:0] cache_data,
   output logic [15:0] req_cnt,
   output logic [15:0] hit_cnt
);

   localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

   logic [1:0]  state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] data_q, data_d;
   logic [15:0] dout_q, dout_d;
   logic        op_wr_q, op_wr_d;
   logic [6:0]  wait_q, wait_d;

   logic w_busy, w_open, w_legal, w_accept, w_reject, w_timeout, w_hit;

   dff_r #(.WIDTH(2), .RST_VAL(ST_IDLE)) u_state_ff (
      .clk (clk),
      .rst (rst),
      .d_i (state_d),
      .q_o (state_q)
   );

   assign w_busy   = (state_q == ST_BUSY);
   assign w_open   = (state_q == ST_IDLE) || (state_q == ST_RESP);
   assign w_legal  = req_legal(rd_in, wr_in, addr_in[0]);
   assign w_accept = w_open & w_legal;
   assign w_reject = w_open & (rd_in | wr_in) & ~w_legal;
   // wait_q counts completed BUSY cycles, so the current cycle is wait_q+1.
   assign w_timeout = w_busy & ~done & (({1'b0, wait_q} + 8'd1) == C_TIMEOUT);
   assign w_hit     = w_busy & done & cache_hit;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      dout_d  = dout_q;
      op_wr_d = op_wr_q;
      wait_d  = wait_q;
      case (state_q)
         ST_IDLE, ST_RESP: begin
            state_d = ST_IDLE;
            if (w_accept) begin
               state_d = ST_BUSY;
               addr_d  = addr_in;
               data_d  = data_in;
               op_wr_d = wr_in;
               wait_d  = 7'd0;
            end
         end
         ST_BUSY: begin
            wait_d = wait_q + 7'd1;
            if (done) begin
               state_d = ST_RESP;
               if (!op_wr_q) dout_d = cache_data;
            end else if (w_timeout) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= 16'h0000;
         data_q  <= 16'h0000;
         dout_q  <= 16'h0000;
         op_wr_q <= 1'b0;
         wait_q  <= 7'd0;
      end else begin
         addr_q  <= addr_d;
         data_q  <= data_d;
         dout_q  <= dout_d;
         op_wr_q <= op_wr_d;
         wait_q  <= wait_d;
      end
   end

   sat_counter16 u_req_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (w_accept),
      .cnt_o (req_cnt)
   );

   sat_counter16 u_hit_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (w_hit),
      .cnt_o (hit_cnt)
   );

   assign data_out   = dout_q;
   assign addr       = addr_q;
   assign data       = data_q;
   assign rd         = w_busy & ~op_wr_q;
   assign wr         = w_busy &  op_wr_q;
   assign stall_proc = w_busy;
   assign done_proc  = (state_q == ST_RESP);
   assign err        = ~rst & (w_reject | w_timeout);

endmodule

`default_nettype wire

// File: tb/tb_cache_req_ctrl.sv
// ============================================================================
// tb_cache_req_ctrl : transaction-level checks of cache_req_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cache_req_ctrl;
   import cache_req_ctrl_pkg::*;

   localparam int TO = TIMEOUT_DEFAULT;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addr_in, data_in, cache_data;
   logic        rd_in, wr_in, done, cache_hit;
   logic [15:0] data_out, addr, data, req_cnt, hit_cnt;
   logic        done_proc, stall_proc, err, rd, wr;

   logic        sat_inc;
   logic [15:0] sat_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] exp_req  = 16'h0;
   logic [15:0] exp_hit  = 16'h0;
   logic [15:0] exp_dout = 16'h0;

   always #5 clk = ~clk;

   cache_req_ctrl #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .addr_in    (addr_in),
      .data_in    (data_in),
      .rd_in      (rd_in),
      .wr_in      (wr_in),
      .data_out   (data_out),
      .done_proc  (done_proc),
      .stall_proc (stall_proc),
      .err        (err),
      .addr       (addr),
      .data       (data),
      .rd         (rd),
      .wr         (wr),
      .done       (done),
      .cache_hit  (cache_hit),
      .cache_data (cache_data),
      .req_cnt    (req_cnt),
      .hit_cnt    (hit_cnt)
   );

   sat_counter16 u_sat (
      .clk   (clk),
      .rst   (rst),
      .inc_i (sat_inc),
      .cnt_o (sat_cnt)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] sat16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   task automatic idle_inputs();
      rd_in = 1'b0; wr_in = 1'b0; done = 1'b0; cache_hit = 1'b0;
      addr_in = 16'($urandom); data_in = 16'($urandom); cache_data = 16'($urandom);
   endtask

   task automatic check_counters(input string tag);
      chk16({tag, "_req_cnt"}, req_cnt, exp_req);
      chk16({tag, "_hit_cnt"}, hit_cnt, exp_hit);
   endtask

   // One cycle with no request; stray done/cache_hit must be ignored.
   task automatic idle_cycle();
      idle_inputs();
      done = 1'($urandom); cache_hit = 1'($urandom);
      #1;
      chk1("idle_err", err, 1'b0);
      @(posedge clk); #1;
      chk1("idle_done_proc", done_proc, 1'b0);
      chk1("idle_stall", stall_proc, 1'b0);
   endtask

   // Present a request now; if accepted, answer with done on BUSY cycle k
   // (k > TO means never). Returns inside the cycle following the outcome.
   task automatic do_txn(input logic rdv, input logic wrv, input logic [15:0] a,
                         input logic [15:0] d, input int k, input logic hit,
                         input logic [15:0] cd);
      logic ok;
      logic fin;
      ok = (rdv ^ wrv) && !a[0];
      rd_in = rdv; wr_in = wrv; addr_in = a; data_in = d;
      done = 1'($urandom); cache_hit = 1'($urandom); cache_data = 16'($urandom);
      #1;
      chk1("req_err", err, !ok);
      @(posedge clk); #1;
      if (!ok) begin
         idle_inputs();
         #1;
         chk1("rej_stall", stall_proc, 1'b0);
         chk1("rej_rd", rd, 1'b0);
         check_counters("rej");
      end else begin
         exp_req = sat16(exp_req);
         fin = 1'b0;
         for (int i = 1; i <= TO && !fin; i++) begin
            rd_in = 1'($urandom); wr_in = 1'($urandom);
            addr_in = 16'($urandom); data_in = 16'($urandom);
            done = (i == k); cache_hit = hit;
            cache_data = (i == k) ? cd : 16'($urandom);
            #1;
            chk1("busy_stall", stall_proc, 1'b1);
            chk1("busy_rd", rd, rdv);
            chk1("busy_wr", wr, wrv);
            chk16("busy_addr", addr, a);
            chk16("busy_data", data, d);
            chk1("busy_err", err, (i == TO) && (k != TO));
            @(posedge clk); #1;
            if (i == k) fin = 1'b1;
         end
         idle_inputs();
         #1;
         if (k <= TO) begin
            if (rdv) exp_dout = cd;
            if (hit) exp_hit = sat16(exp_hit);
            chk1("resp_done_proc", done_proc, 1'b1);
            chk1("resp_stall", stall_proc, 1'b0);
            chk1("resp_err", err, 1'b0);
            chk1("resp_rd", rd | wr, 1'b0);
            chk16("resp_data_out", data_out, exp_dout);
         end else begin
            chk1("to_done_proc", done_proc, 1'b0);
            chk1("to_stall", stall_proc, 1'b0);
            chk1("to_err", err, 1'b0);
            chk1("to_rd", rd | wr, 1'b0);
         end
         check_counters("txn");
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk16({tag, "_data_out"}, data_out, 16'h0);
      chk16({tag, "_addr"}, addr, 16'h0);
      chk16({tag, "_data"}, data, 16'h0);
      chk1({tag, "_rd"}, rd, 1'b0);
      chk1({tag, "_wr"}, wr, 1'b0);
      chk1({tag, "_done_proc"}, done_proc, 1'b0);
      chk1({tag, "_err"}, err, 1'b0);
      chk1({tag, "_stall"}, stall_proc, 1'b0);
      check_counters(tag);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired before end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      logic rdv, wrv;
      logic [15:0] a;
      int sel, k;

      rst = 1'b1; sat_inc = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      idle_cycle();

      // Read hit with minimum latency
      do_txn(1'b1, 1'b0, 16'h0A24, 16'h1111, 1, 1'b1, 16'hBEEF);
      idle_cycle();

      // Write miss answered after 20 BUSY cycles
      do_txn(1'b0, 1'b1, 16'h1230, 16'h5555, 20, 1'b0, 16'hDEAD);
      idle_cycle();

      // Illegal requests
      do_txn(1'b1, 1'b1, 16'h0040, 16'h0000, 1, 1'b0, 16'h0);
      do_txn(1'b1, 1'b0, 16'h0003, 16'h0000, 1, 1'b0, 16'h0);
      idle_cycle();

      // Timeout, then done on the timeout cycle itself
      do_txn(1'b1, 1'b0, 16'h0200, 16'h0, TO + 5, 1'b1, 16'h1234);
      do_txn(1'b1, 1'b0, 16'h0202, 16'h0, TO, 1'b1, 16'h4321);
      idle_cycle();

      // Back-to-back request during RESP, then reset mid-BUSY
      do_txn(1'b1, 1'b0, 16'h0300, 16'h0, 2, 1'b0, 16'hCAFE);
      rd_in = 1'b1; wr_in = 1'b0; addr_in = 16'h0400;
      #1;
      chk1("b2b_err", err, 1'b0);
      @(posedge clk); #1;
      exp_req = sat16(exp_req);
      idle_inputs();
      #1;
      chk1("b2b_stall", stall_proc, 1'b1);
      chk1("b2b_rd", rd, 1'b1);
      chk16("b2b_addr", addr, 16'h0400);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      exp_req = 16'h0; exp_hit = 16'h0; exp_dout = 16'h0;
      check_all_zero("midbusy_rst");
      // Reset wins over a simultaneous legal request
      rd_in = 1'b1; addr_in = 16'h0500;
      @(posedge clk); #1;
      rst = 1'b0;
      idle_inputs();
      done = 1'b1;
      #1;
      chk1("rst_accept_stall", stall_proc, 1'b0);
      chk16("rst_accept_req_cnt", req_cnt, 16'h0);
      idle_cycle();

      // Randomised transactions
      repeat (40) begin
         sel = $urandom_range(0, 9);
         rdv = 1'($urandom); wrv = ~rdv;
         a = 16'($urandom) & 16'hFFFE;
         if (sel == 0) begin rdv = 1'b1; wrv = 1'b1; end
         if (sel == 1) a[0] = 1'b1;
         k = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 2, TO + 3) : $urandom_range(1, 6);
         do_txn(rdv, wrv, a, 16'($urandom), k, 1'($urandom), 16'($urandom));
         if ($urandom_range(0, 1) == 0) idle_cycle();
      end

      // Three hit requests, then saturation of the counter primitive
      repeat (3) do_txn(1'b1, 1'b0, 16'h0600, 16'h0, 1, 1'b1, 16'h0F0F);
      idle_cycle();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_req = 16'h0; exp_hit = 16'h0;
      sat_inc = 1'b1;
      repeat (65534) @(posedge clk);
      #1;
      chk16("sat_preload", sat_cnt, 16'hFFFE);
      repeat (3) @(posedge clk);
      #1;
      chk16("sat_hold", sat_cnt, 16'hFFFF);
      sat_inc = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
